// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding NUM_WB_PORTS register-file write
// ports and one NZCV write port, granted round-robin with at most one flag write per cycle.
package reg_pkg;
    localparam int WORD_SIZE     = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int IDX_W         = $clog2(NUM_PHYS_REGS);

    typedef struct packed {
        logic             en;
        logic [IDX_W-1:0] index_in;
        logic [WORD_SIZE-1:0] data_in;
    } RegFileWritePort;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index_in;
        logic [3:0]       nzcv;
    } NZCVWritePort;
endpackage

module regfile_wb_arbiter #(
    parameter int WORD_SIZE     = reg_pkg::WORD_SIZE,
    parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    parameter int NUM_SRCS      = 4,
    parameter int NUM_WB_PORTS  = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_SRCS-1:0]                             src_valid,
    output logic [NUM_SRCS-1:0]                             src_ready,
    input  logic [NUM_SRCS-1:0][$clog2(NUM_PHYS_REGS)-1:0]  src_index,
    input  logic [NUM_SRCS-1:0][WORD_SIZE-1:0]              src_data,
    input  logic [NUM_SRCS-1:0]                             src_nzcv_valid,
    input  logic [NUM_SRCS-1:0][$clog2(NUM_PHYS_REGS)-1:0]  src_nzcv_index,
    input  logic [NUM_SRCS-1:0][3:0]                        src_nzcv,
    output reg_pkg::RegFileWritePort [NUM_WB_PORTS-1:0]     write_ports,
    output reg_pkg::NZCVWritePort                           nzcv_write_port
);
    localparam int IDX_W = $clog2(NUM_PHYS_REGS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
    localparam int NP_W  = $clog2(NUM_WB_PORTS + 1);

    typedef struct packed {
        logic [IDX_W-1:0]     index;
        logic [WORD_SIZE-1:0] data;
        logic                 nzcv_valid;
        logic [IDX_W-1:0]     nzcv_index;
        logic [3:0]           nzcv;
    } entry_t;

    entry_t                  head [NUM_SRCS];
    logic [NUM_SRCS-1:0]     not_empty;
    logic [NUM_SRCS-1:0]     grant;
    logic [SRC_W-1:0]        rr_ptr_reg;
    logic [SRC_W-1:0]        rr_ptr_next;
    logic [NUM_WB_PORTS-1:0] slot_vld;
    logic [SRC_W-1:0]        slot_src [NUM_WB_PORTS];
    logic                    nzcv_taken;
    logic [SRC_W-1:0]        nzcv_src;
    logic                    dup_idx;

    reg_pkg::RegFileWritePort [NUM_WB_PORTS-1:0] write_ports_reg;
    reg_pkg::NZCVWritePort                       nzcv_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRCS; gi++) begin : g_src
            entry_t           mem_reg [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;
            logic             ready_reg;
            logic             push;
            logic             pop;

            assign push       = src_valid[gi] & ready_reg;
            assign pop        = grant[gi];
            assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

            always_ff @(posedge clk) begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= {src_index[gi], src_data[gi], src_nzcv_valid[gi],
                                            src_nzcv_index[gi], src_nzcv[gi]};
                end
            end

            // Ready is registered from next-state occupancy so it never depends on src_valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    ready_reg  <= 1'b0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    count_reg <= count_next;
                    ready_reg <= (count_next < CNT_W'(FIFO_DEPTH));
                end
            end

            assign head[gi]      = mem_reg[rd_ptr_reg];
            assign not_empty[gi] = (count_reg != '0);
            assign src_ready[gi] = ready_reg;
        end
    endgenerate

    // Round-robin scan; a second flag-writing head in the same cycle is skipped, not blocking.
    always_comb begin
        logic [SRC_W-1:0] s;
        logic [NP_W-1:0]  n;
        grant       = '0;
        slot_vld    = '0;
        nzcv_taken  = 1'b0;
        nzcv_src    = '0;
        rr_ptr_next = rr_ptr_reg;
        s           = '0;
        n           = '0;
        for (int k = 0; k < NUM_WB_PORTS; k++) slot_src[k] = '0;
        for (int off = 0; off < NUM_SRCS; off++) begin
            s = SRC_W'((int'(rr_ptr_reg) + off) % NUM_SRCS);
            if (not_empty[s] && (n < NP_W'(NUM_WB_PORTS)) && !(head[s].nzcv_valid && nzcv_taken)) begin
                grant[s] = 1'b1;
                for (int k = 0; k < NUM_WB_PORTS; k++) begin
                    if (n == NP_W'(k)) begin
                        slot_vld[k] = 1'b1;
                        slot_src[k] = s;
                    end
                end
                if (head[s].nzcv_valid) begin
                    nzcv_taken = 1'b1;
                    nzcv_src   = s;
                end
                n           = n + NP_W'(1);
                rr_ptr_next = (s == SRC_W'(NUM_SRCS - 1)) ? '0 : s + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg      <= '0;
            write_ports_reg <= '0;
            nzcv_reg        <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            for (int k = 0; k < NUM_WB_PORTS; k++) begin
                write_ports_reg[k] <= slot_vld[k] ?
                    {1'b1, head[slot_src[k]].index, head[slot_src[k]].data} : '0;
            end
            nzcv_reg <= nzcv_taken ?
                {1'b1, head[nzcv_src].nzcv_index, head[nzcv_src].nzcv} : '0;
        end
    end

    assign write_ports     = write_ports_reg;
    assign nzcv_write_port = nzcv_reg;

    // Two writes to one physical register in a cycle means rename handed out a duplicate.
    always_comb begin
        dup_idx = 1'b0;
        for (int a = 0; a < NUM_WB_PORTS; a++) begin
            for (int b = a + 1; b < NUM_WB_PORTS; b++) begin
                if (write_ports_reg[a].en && write_ports_reg[b].en &&
                    (write_ports_reg[a].index_in == write_ports_reg[b].index_in)) begin
                    dup_idx = 1'b1;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !dup_idx);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: per-source expected queues filled on handshake,
// drained as writes appear, plus directed cycle-exact checks of latency and arbitration.
module tb_regfile_wb_arbiter;
    localparam int NS = 4;
    localparam int NP = 2;
    localparam int IW = reg_pkg::IDX_W;
    localparam int WS = reg_pkg::WORD_SIZE;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [NS-1:0]          src_valid;
    logic [NS-1:0]          src_ready;
    logic [NS-1:0][IW-1:0]  src_index;
    logic [NS-1:0][WS-1:0]  src_data;
    logic [NS-1:0]          src_nzcv_valid;
    logic [NS-1:0][IW-1:0]  src_nzcv_index;
    logic [NS-1:0][3:0]     src_nzcv;
    reg_pkg::RegFileWritePort [NP-1:0] write_ports;
    reg_pkg::NZCVWritePort             nzcv_write_port;

    regfile_wb_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_index      (src_index),
        .src_data       (src_data),
        .src_nzcv_valid (src_nzcv_valid),
        .src_nzcv_index (src_nzcv_index),
        .src_nzcv       (src_nzcv),
        .write_ports    (write_ports),
        .nzcv_write_port(nzcv_write_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [WS-1:0] data;
        logic          nv;
        logic [IW-1:0] nidx;
        logic [3:0]    nzcv;
    } ent_t;

    ent_t     stim_q [NS][$];
    ent_t     exp_q  [NS][$];
    logic [NS-1:0] acc = '0;
    int n_vec = 0;
    int n_err = 0;
    int wr_cnt [NS];
    int total_wr = 0;
    bit track_rdy = 0;
    bit rdy2_dropped = 0;
    int src2_acc = 0;
    int src2_acc_at_drop = 0;
    int   mon_s;
    int   mon_nzp;
    ent_t mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input int s, input int seq, input int idx,
                                input bit nv, input int nidx, input int nz);
        ent_t e;
        logic [3:0] sid;
        sid    = 4'(s);
        e.idx  = IW'(idx);
        e.data = {sid, 28'(seq)};
        e.nv   = nv;
        e.nidx = IW'(nidx);
        e.nzcv = 4'(nz);
        return e;
    endfunction

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < NS; i++) t += stim_q[i].size() + exp_q[i].size();
        return t;
    endfunction

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (stim_q[i].size() > 0) begin
                src_valid[i]      = 1'b1;
                src_index[i]      = stim_q[i][0].idx;
                src_data[i]       = stim_q[i][0].data;
                src_nzcv_valid[i] = stim_q[i][0].nv;
                src_nzcv_index[i] = stim_q[i][0].nidx;
                src_nzcv[i]       = stim_q[i][0].nzcv;
            end else begin
                src_valid[i]      = 1'b0;
                src_index[i]      = '0;
                src_data[i]       = '0;
                src_nzcv_valid[i] = 1'b0;
                src_nzcv_index[i] = '0;
                src_nzcv[i]       = '0;
            end
        end
    endtask

    // One clock: retire accepted stimulus after the edge, re-drive, then land on the negedge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && stim_q[i].size() > 0) stim_q[i].delete(0);
        end
        drive();
        @(negedge clk);
    endtask

    task automatic load_stream(input int s, input int n, input bit rnd_nzcv);
        for (int j = 0; j < n; j++) begin
            stim_q[s].push_back(mk(s, 'h1000 + j, s * 16 + (j % 16),
                                   rnd_nzcv ? bit'($urandom_range(0, 1)) : 1'b0,
                                   $urandom_range(0, 63), $urandom_range(0, 15)));
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc = 0;
        while (pending() > 0 && cyc < budget) begin
            step();
            cyc++;
        end
        repeat (3) step();
        check(tag, 64'(pending()), 64'(0));
    endtask

    // Output side of the scoreboard, then record which handshakes will complete at the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc = '0;
        end else begin
            mon_nzp = 0;
            for (int k = 0; k < NP; k++) begin
                if (write_ports[k].en) begin
                    mon_s = int'(write_ports[k].data_in[WS-1 -: 4]);
                    if (mon_s >= NS || exp_q[mon_s].size() == 0) begin
                        check($sformatf("spurious_p%0d", k), 64'(write_ports[k].data_in), 64'(0));
                    end else begin
                        mon_e = exp_q[mon_s].pop_front();
                        check($sformatf("p%0d_idx", k), 64'(write_ports[k].index_in), 64'(mon_e.idx));
                        check($sformatf("p%0d_data", k), 64'(write_ports[k].data_in), 64'(mon_e.data));
                        if (mon_e.nv) begin
                            mon_nzp++;
                            check($sformatf("p%0d_nzcv", k),
                                  64'({nzcv_write_port.valid, nzcv_write_port.index_in, nzcv_write_port.nzcv}),
                                  64'({1'b1, mon_e.nidx, mon_e.nzcv}));
                        end
                        wr_cnt[mon_s]++;
                        total_wr++;
                        $display("wb port%0d src%0d idx=%0d data=%08h nzcv_v=%0b",
                                 k, mon_s, write_ports[k].index_in, write_ports[k].data_in, mon_e.nv);
                    end
                    if (k > 0) check("port_pack", 64'(write_ports[k-1].en), 64'(1));
                end else begin
                    check($sformatf("idle_p%0d", k),
                          64'({write_ports[k].index_in, write_ports[k].data_in}), 64'(0));
                end
            end
            check("nzcv_count", 64'(nzcv_write_port.valid), 64'(mon_nzp));
            if (!nzcv_write_port.valid)
                check("nzcv_idle", 64'({nzcv_write_port.index_in, nzcv_write_port.nzcv}), 64'(0));
            for (int i = 0; i < NS; i++) begin
                acc[i] = src_valid[i] & src_ready[i];
                if (acc[i]) begin
                    exp_q[i].push_back(stim_q[i][0]);
                    if (i == 2) src2_acc++;
                end
            end
            if (track_rdy && !src_ready[2] && !rdy2_dropped) begin
                rdy2_dropped     = 1'b1;
                src2_acc_at_drop = src2_acc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ent_t a;
        ent_t b;
        ent_t c;
        reg_pkg::RegFileWritePort wexp;
        int snap [NS];
        int snap_total;

        for (int i = 0; i < NS; i++) wr_cnt[i] = 0;
        drive();
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_p0", 64'(write_ports[0]), 64'(0));
        check("rst_p1", 64'(write_ports[1]), 64'(0));
        check("rst_nzcv", 64'(nzcv_write_port), 64'(0));
        check("rst_ready", 64'(src_ready), 64'(0));
        rst_n = 1'b1;
        #1 check("ready_at_release", 64'(src_ready), 64'(0));
        step();
        check("ready_after_release", 64'(src_ready), 64'(4'hF));

        // All four sources once with rr_ptr at 0: two pairs in source order.
        for (int i = 0; i < NS; i++) stim_q[i].push_back(mk(i, 'h200 + i, i + 1, 0, 0, 0));
        step();
        step();
        check("t2_early", 64'({write_ports[1].en, write_ports[0].en}), 64'(0));
        step();
        check("t2_c1_p0", 64'({write_ports[0].en, write_ports[0].index_in}), 64'({1'b1, IW'(1)}));
        check("t2_c1_p1", 64'({write_ports[1].en, write_ports[1].index_in}), 64'({1'b1, IW'(2)}));
        step();
        check("t2_c2_p0", 64'({write_ports[0].en, write_ports[0].index_in}), 64'({1'b1, IW'(3)}));
        check("t2_c2_p1", 64'({write_ports[1].en, write_ports[1].index_in}), 64'({1'b1, IW'(4)}));
        step();
        check("t2_c3_idle", 64'({write_ports[1].en, write_ports[0].en}), 64'(0));

        // Two flag-writing heads: the second is skipped in favour of src2.
        a = mk(0, 'h300, 10, 1, 20, 4'h8);
        b = mk(1, 'h301, 11, 1, 21, 4'h4);
        c = mk(2, 'h302, 12, 0, 0, 0);
        stim_q[0].push_back(a);
        stim_q[1].push_back(b);
        stim_q[2].push_back(c);
        step();
        step();
        step();
        check("t3_c1_p0", 64'(write_ports[0].index_in), 64'(a.idx));
        check("t3_c1_p1", 64'(write_ports[1].index_in), 64'(c.idx));
        check("t3_c1_nzcv", 64'(nzcv_write_port), 64'({1'b1, a.nidx, a.nzcv}));
        step();
        check("t3_c2_p0", 64'(write_ports[0].index_in), 64'(b.idx));
        check("t3_c2_p1_en", 64'(write_ports[1].en), 64'(0));
        check("t3_c2_nzcv", 64'(nzcv_write_port), 64'({1'b1, b.nidx, b.nzcv}));
        step();

        // Single entry: one-cycle latency after the handshake cycle, held for exactly one cycle.
        stim_q[0].push_back(mk(0, 'hDEAD, 5, 0, 0, 0));
        step();
        step();
        check("t1_early", 64'(write_ports[0].en), 64'(0));
        step();
        wexp.en       = 1'b1;
        wexp.index_in = IW'(5);
        wexp.data_in  = 32'h0000_DEAD;
        check("t1_p0", 64'(write_ports[0]), 64'(wexp));
        check("t1_p1_en", 64'(write_ports[1].en), 64'(0));
        check("t1_nzcv_v", 64'(nzcv_write_port.valid), 64'(0));
        step();
        check("t1_after", 64'({write_ports[1].en, write_ports[0].en}), 64'(0));

        // src2 burst of five against three saturating neighbours, random flag writes.
        snap[2]   = wr_cnt[2];
        src2_acc  = 0;
        track_rdy = 1'b1;
        load_stream(0, 12, 1);
        load_stream(1, 12, 1);
        load_stream(3, 12, 1);
        load_stream(2, 5, 1);
        drain("t4_drain", 400);
        track_rdy = 1'b0;
        check("t4_src2_acc", 64'(src2_acc), 64'(5));
        check("t4_src2_writes", 64'(wr_cnt[2] - snap[2]), 64'(5));
        check("t4_rdy_dropped", 64'(rdy2_dropped), 64'(1));
        check("t4_drop_after2", 64'(src2_acc_at_drop >= 2), 64'(1));

        // Continuous traffic: steady state is two writes per cycle, each source every other cycle.
        for (int i = 0; i < NS; i++) load_stream(i, 80, 0);
        repeat (10) step();
        snap_total = total_wr;
        for (int i = 0; i < NS; i++) snap[i] = wr_cnt[i];
        repeat (100) step();
        check("t6_total", 64'(total_wr - snap_total), 64'(200));
        for (int i = 0; i < NS; i++)
            check($sformatf("t6_src%0d", i), 64'(wr_cnt[i] - snap[i]), 64'(50));
        drain("t6_drain", 500);

        // Asynchronous reset with entries buffered: everything in flight is discarded.
        for (int i = 0; i < NS; i++) load_stream(i, 20, 1);
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        check("t5_p0", 64'(write_ports[0]), 64'(0));
        check("t5_p1", 64'(write_ports[1]), 64'(0));
        check("t5_nzcv", 64'(nzcv_write_port), 64'(0));
        check("t5_ready", 64'(src_ready), 64'(0));
        for (int i = 0; i < NS; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
        end
        acc = '0;
        drive();
        step();
        step();
        rst_n = 1'b1;
        #1 check("t5_ready_rel", 64'(src_ready), 64'(0));
        snap_total = total_wr;
        step();
        check("t5_ready_up", 64'(src_ready), 64'(4'hF));
        repeat (10) step();
        check("t5_nostale", 64'(total_wr - snap_total), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
